// File: rtl/s_axi_interface_pkg.sv
// ---------------------------------------------------------------------------
// s_axi_interface_pkg
// Shared constants for the AXI4-Lite image/coprocessor register slave:
//   - default parameter values for s_axi_interface
//   - word-index register addresses (status, control)
//   - AXI response codes
//   - status word bit positions
//   - channel state type shared by the write and read FSMs
// ---------------------------------------------------------------------------
package s_axi_interface_pkg;

  localparam int DEF_AXI_DATA_WIDTH  = 32;
  localparam int DEF_AXI_ADDR_WIDTH  = 32;
  localparam int DEF_IMAGE_SIZE      = 256;
  localparam int DEF_IMAGE_SIZE_BITS = 8;
  localparam int DEF_PIXEL_MAX_VALUE = 255;
  localparam int DEF_PIXEL_BITS      = 8;

  // Addresses are word indices, not byte offsets
  localparam int ADDR_STATUS = 0;
  localparam int ADDR_CTRL   = DEF_IMAGE_SIZE;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_VALID_BIT = 31;
  localparam int STATUS_DIGIT_MSB = 7;
  localparam int STATUS_DIGIT_LSB = 0;

  // Each AXI channel pair is either waiting for an address or holding a response
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RESP = 1'b1
  } chState_e;

endpackage

// File: rtl/s_axi_interface.sv
// ---------------------------------------------------------------------------
// s_axi_interface
// AXI4-Lite slave holding an image buffer for a digit-inference coprocessor.
// Write addresses 0..IMAGE_SIZE-1 store pixels, write address IMAGE_SIZE is
// the control register (bit0 = NEW_IMAGE). Read address 0 returns the status
// word {COPROCESSOR_RDY at bit 31, INFERED_DIGIT at bits 7:0}.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   AW*/W*/B*             write address, write data, write response channels
//   AR*/R*                read address, read data channels
//   COPROCESSOR_RDY       inference result valid (sampled on read handshake)
//   INFERED_DIGIT         inferred digit (sampled on read handshake)
//   IMAGE                 live view of all pixel registers
//   NEW_IMAGE             control register bit0
//
// Build option: define S_AXI_INTERFACE_SLVERR_EN to answer out-of-range
// accesses with SLVERR and to make the control register readable at
// address IMAGE_SIZE. Without it, such accesses complete with OKAY.
// ---------------------------------------------------------------------------
module s_axi_interface
  import s_axi_interface_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = DEF_AXI_DATA_WIDTH,
  parameter int AXI_ADDR_WIDTH  = DEF_AXI_ADDR_WIDTH,
  parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
  parameter int IMAGE_SIZE_BITS = DEF_IMAGE_SIZE_BITS,
  parameter int PIXEL_MAX_VALUE = DEF_PIXEL_MAX_VALUE,
  parameter int PIXEL_BITS      = DEF_PIXEL_BITS
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]                ARPROT,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  input  logic                      COPROCESSOR_RDY,
  input  logic [7:0]                INFERED_DIGIT,
  output logic [PIXEL_BITS-1:0]     IMAGE [IMAGE_SIZE],
  output logic                      NEW_IMAGE
);

  localparam logic [AXI_ADDR_WIDTH-1:0] STATUS_ADDR = AXI_ADDR_WIDTH'(ADDR_STATUS);
  localparam logic [AXI_ADDR_WIDTH-1:0] CTRL_ADDR   = AXI_ADDR_WIDTH'(IMAGE_SIZE);

  chState_e                  wrState_q;
  chState_e                  rdState_q;
  logic                      awReady_q;
  logic                      bValid_q;
  logic [1:0]                bResp_q;
  logic                      arReady_q;
  logic                      rValid_q;
  logic [1:0]                rResp_q;
  logic [AXI_DATA_WIDTH-1:0] rData_q;
  logic [PIXEL_BITS-1:0]     pixel_q [IMAGE_SIZE];
  logic                      newImage_q;

  logic                      wrIsPixel;
  logic                      wrIsCtrl;
  logic [1:0]                bResp_d;
  logic [AXI_DATA_WIDTH-1:0] rData_d;
  logic [1:0]                rResp_d;
  logic                      wrFire;
  logic                      rdFire;
  logic                      unusedInputs;

  // A transfer completes on the edge where our registered ready meets valid
  assign wrFire = awReady_q & AWVALID & WVALID;
  assign rdFire = arReady_q & ARVALID;

  // Decode the write target and the response the write will earn
  always_comb begin
    wrIsPixel = (AWADDR < CTRL_ADDR);
    wrIsCtrl  = (AWADDR == CTRL_ADDR);
    bResp_d   = RESP_OKAY;
`ifdef S_AXI_INTERFACE_SLVERR_EN
    if (!wrIsPixel && !wrIsCtrl) begin
      bResp_d = RESP_SLVERR;
    end
`endif
  end

  // Build the read data word for the address presented on AR
  always_comb begin
    rData_d = '0;
    rResp_d = RESP_OKAY;
    if (ARADDR == STATUS_ADDR) begin
      rData_d[STATUS_VALID_BIT]                  = COPROCESSOR_RDY;
      rData_d[STATUS_DIGIT_MSB:STATUS_DIGIT_LSB] = INFERED_DIGIT;
    end
`ifdef S_AXI_INTERFACE_SLVERR_EN
    else if (ARADDR == CTRL_ADDR) begin
      rData_d[0] = newImage_q;
    end
    else begin
      rResp_d = RESP_SLVERR;
    end
`endif
  end

  // Write channel FSM plus the register file it owns. AWREADY/WREADY is
  // raised for one cycle once both valids are seen in IDLE; IDLE implies
  // BVALID is low, so a new write cannot start until the B handshake ends.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrState_q  <= CH_IDLE;
      awReady_q  <= 1'b0;
      bValid_q   <= 1'b0;
      bResp_q    <= RESP_OKAY;
      newImage_q <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        pixel_q[i] <= '0;
      end
    end else begin
      case (wrState_q)
        CH_IDLE: begin
          if (wrFire) begin
            awReady_q <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= bResp_d;
            wrState_q <= CH_RESP;
            if (WSTRB[0]) begin
              if (wrIsPixel) begin
                pixel_q[AWADDR[IMAGE_SIZE_BITS-1:0]] <= WDATA[PIXEL_BITS-1:0];
              end else if (wrIsCtrl) begin
                newImage_q <= WDATA[0];
              end
            end
          end else begin
            awReady_q <= AWVALID & WVALID;
          end
        end
        CH_RESP: begin
          if (BREADY) begin
            bValid_q  <= 1'b0;
            wrState_q <= CH_IDLE;
          end
        end
        default: wrState_q <= CH_IDLE;
      endcase
    end
  end

  // Read channel FSM; RDATA is captured on the AR handshake and held
  // unchanged until the master accepts it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdState_q <= CH_IDLE;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rResp_q   <= RESP_OKAY;
      rData_q   <= '0;
    end else begin
      case (rdState_q)
        CH_IDLE: begin
          if (rdFire) begin
            arReady_q <= 1'b0;
            rValid_q  <= 1'b1;
            rData_q   <= rData_d;
            rResp_q   <= rResp_d;
            rdState_q <= CH_RESP;
          end else begin
            arReady_q <= ARVALID;
          end
        end
        CH_RESP: begin
          if (RREADY) begin
            rValid_q  <= 1'b0;
            rdState_q <= CH_IDLE;
          end
        end
        default: rdState_q <= CH_IDLE;
      endcase
    end
  end

  assign AWREADY   = awReady_q;
  assign WREADY    = awReady_q;
  assign BVALID    = bValid_q;
  assign BRESP     = bResp_q;
  assign ARREADY   = arReady_q;
  assign RVALID    = rValid_q;
  assign RRESP     = rResp_q;
  assign RDATA     = rData_q;
  assign IMAGE     = pixel_q;
  assign NEW_IMAGE = newImage_q;

  // Protection bits, upper strobe lanes and upper data bits carry no meaning here
  assign unusedInputs = ^{AWPROT, ARPROT, WSTRB[3:1],
                          WDATA[AXI_DATA_WIDTH-1:PIXEL_BITS],
                          (PIXEL_MAX_VALUE != 0)};

endmodule

// File: tb/tb_s_axi_interface.sv
// ---------------------------------------------------------------------------
// tb_s_axi_interface
// Self-checking bench for s_axi_interface. Stimulus tasks push the expected
// B/R responses into queues from a behavioural image model; a monitor pops
// and compares whenever a response handshake is seen.
// Honours S_AXI_INTERFACE_SLVERR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_s_axi_interface;
  import s_axi_interface_pkg::*;

  localparam int N = 256;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rExp_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        COPROCESSOR_RDY;
  logic [7:0]  INFERED_DIGIT;
  logic [7:0]  IMAGE [N];
  logic        NEW_IMAGE;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  modelImg [N];
  logic        modelNewImg;
  logic [1:0]  bQueue [$];
  rExp_t       rQueue [$];

  s_axi_interface dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .AWADDR          (AWADDR),
    .AWPROT          (AWPROT),
    .AWVALID         (AWVALID),
    .AWREADY         (AWREADY),
    .WDATA           (WDATA),
    .WSTRB           (WSTRB),
    .WVALID          (WVALID),
    .WREADY          (WREADY),
    .BRESP           (BRESP),
    .BVALID          (BVALID),
    .BREADY          (BREADY),
    .ARADDR          (ARADDR),
    .ARPROT          (ARPROT),
    .ARVALID         (ARVALID),
    .ARREADY         (ARREADY),
    .RDATA           (RDATA),
    .RRESP           (RRESP),
    .RVALID          (RVALID),
    .RREADY          (RREADY),
    .COPROCESSOR_RDY (COPROCESSOR_RDY),
    .INFERED_DIGIT   (INFERED_DIGIT),
    .IMAGE           (IMAGE),
    .NEW_IMAGE       (NEW_IMAGE)
  );

  // Free-running 100 MHz clock
  always #5 ACLK = ~ACLK;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // A bounded wait that expired counts as a failed comparison
  task automatic flagTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  function automatic int countImageErrors();
    int errs = 0;
    for (int i = 0; i < N; i++) begin
      if (IMAGE[i] !== modelImg[i]) errs++;
    end
    return errs;
  endfunction

  // Monitor: every completed B or R handshake is checked against the queue head
  initial begin
    logic [1:0] expB;
    rExp_t      expR;
    forever begin
      @(negedge ACLK);
      if (!ARESET && BVALID && BREADY) begin
        if (bQueue.size() == 0) begin
          flagTimeout("unexpected_B_response");
        end else begin
          expB = bQueue.pop_front();
          checkOutput("BRESP", 32'(BRESP), 32'(expB));
          checkOutput("IMAGE_error_count", 32'(countImageErrors()), 32'd0);
          checkOutput("NEW_IMAGE", 32'(NEW_IMAGE), 32'(modelNewImg));
        end
      end
      if (!ARESET && RVALID && RREADY) begin
        if (rQueue.size() == 0) begin
          flagTimeout("unexpected_R_response");
        end else begin
          expR = rQueue.pop_front();
          checkOutput("RDATA", RDATA, expR.data);
          checkOutput("RRESP", 32'(RRESP), 32'(expR.resp));
        end
      end
    end
  end

  task automatic doReset();
    ARESET  = 1'b1;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    BREADY  = 1'b1;
    RREADY  = 1'b1;
    bQueue.delete();
    rQueue.delete();
    for (int i = 0; i < N; i++) modelImg[i] = 8'h00;
    modelNewImg = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  // One complete write; the model is updated and the response queued up front
  task automatic writeTxn(input int addr, input logic [31:0] data, input logic [3:0] strb,
                          input int stall);
    logic [1:0] exp;
    int         n;
    exp = RESP_OKAY;
    if (addr < N) begin
      if (strb[0]) modelImg[addr] = data[7:0];
    end else if (addr == ADDR_CTRL) begin
      if (strb[0]) modelNewImg = data[0];
    end else begin
`ifdef S_AXI_INTERFACE_SLVERR_EN
      exp = RESP_SLVERR;
`endif
    end
    bQueue.push_back(exp);
    BREADY  = (stall == 0);
    AWADDR  = 32'(addr);
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
    if (!AWREADY) begin
      flagTimeout("AWREADY_wait");
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      BREADY  = 1'b1;
      return;
    end
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge ACLK);
      #1 BREADY = 1'b1;
    end
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(BVALID && BREADY) && n < 50);
    if (!(BVALID && BREADY)) flagTimeout("BVALID_wait");
    @(posedge ACLK);
    #1;
  endtask

  // One complete read; expected word follows the register map rules
  task automatic readTxn(input int addr, input logic rdy, input logic [7:0] digit,
                         input int stall);
    rExp_t e;
    int    n;
    e.data = 32'h0;
    e.resp = RESP_OKAY;
    if (addr == ADDR_STATUS) begin
      e.data = (rdy ? 32'h8000_0000 : 32'h0) | 32'(digit);
    end
`ifdef S_AXI_INTERFACE_SLVERR_EN
    else if (addr == ADDR_CTRL) begin
      e.data = 32'(modelNewImg);
    end else begin
      e.resp = RESP_SLVERR;
    end
`endif
    rQueue.push_back(e);
    COPROCESSOR_RDY = rdy;
    INFERED_DIGIT   = digit;
    RREADY          = (stall == 0);
    ARADDR          = 32'(addr);
    ARVALID         = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!ARREADY && n < 50);
    if (!ARREADY) begin
      flagTimeout("ARREADY_wait");
      ARVALID = 1'b0;
      RREADY  = 1'b1;
      return;
    end
    @(posedge ACLK);
    #1 ARVALID = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge ACLK);
      #1 RREADY = 1'b1;
    end
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(RVALID && RREADY) && n < 50);
    if (!(RVALID && RREADY)) flagTimeout("RVALID_wait");
    @(posedge ACLK);
    #1;
  endtask

  // Random mix of writes, reads and overlapping write+read pairs
  task automatic applyStimulus(input int iterations);
    int          op;
    int          wAddr;
    int          rAddr;
    int          sel;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic        rdy;
    logic [7:0]  digit;
    int          wStall;
    int          rStall;
    for (int it = 0; it < iterations; it++) begin
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel < 7)       wAddr = $urandom_range(0, N - 1);
      else if (sel == 7) wAddr = ADDR_CTRL;
      else               wAddr = $urandom_range(N + 1, 1023);
      sel = $urandom_range(0, 9);
      if (sel < 5)       rAddr = ADDR_STATUS;
      else if (sel == 5) rAddr = (op == 2) ? ADDR_STATUS : ADDR_CTRL;
      else if (sel < 8)  rAddr = $urandom_range(1, N - 1);
      else               rAddr = $urandom_range(N + 1, 1023);
      wData  = $urandom();
      wStrb  = 4'($urandom_range(0, 15));
      rdy    = 1'($urandom_range(0, 1));
      digit  = 8'($urandom_range(0, 255));
      wStall = $urandom_range(0, 3);
      rStall = $urandom_range(0, 3);
      case (op)
        0: writeTxn(wAddr, wData, wStrb, wStall);
        1: readTxn(rAddr, rdy, digit, rStall);
        default: begin
          fork
            writeTxn(wAddr, wData, wStrb, wStall);
            readTxn(rAddr, rdy, digit, rStall);
          join
        end
      endcase
    end
  endtask

  // Hard stop in case something upstream wedges the run
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  d;
    bit          sawReady;
    bit          sawBDrop;
    int          n;

    AWADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = '0;
    ARADDR = '0; ARPROT = '0;
    COPROCESSOR_RDY = 1'b0; INFERED_DIGIT = '0;
    doReset();

    $display("[TB] reset state");
    @(negedge ACLK);
    checkOutput("rst_AWREADY", 32'(AWREADY), 32'd0);
    checkOutput("rst_WREADY", 32'(WREADY), 32'd0);
    checkOutput("rst_BVALID", 32'(BVALID), 32'd0);
    checkOutput("rst_BRESP", 32'(BRESP), 32'd0);
    checkOutput("rst_ARREADY", 32'(ARREADY), 32'd0);
    checkOutput("rst_RVALID", 32'(RVALID), 32'd0);
    checkOutput("rst_RRESP", 32'(RRESP), 32'd0);
    checkOutput("rst_RDATA", RDATA, 32'd0);
    checkOutput("rst_NEW_IMAGE", 32'(NEW_IMAGE), 32'd0);
    checkOutput("rst_IMAGE_error_count", 32'(countImageErrors()), 32'd0);
    @(posedge ACLK);
    #1;

    $display("[TB] fill all pixels");
    for (int i = 0; i < N; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i == 56) d = 8'd3;
      if (i == 57) d = 8'd32;
      if (i == 58) d = 8'd81;
      if (i == 76) d = 8'd244;
      r = $urandom();
      r[7:0] = d;
      writeTxn(i, r, 4'h1, 0);
    end
    checkOutput("IMAGE[56]", 32'(IMAGE[56]), 32'd3);
    checkOutput("IMAGE[57]", 32'(IMAGE[57]), 32'd32);
    checkOutput("IMAGE[58]", 32'(IMAGE[58]), 32'd81);
    checkOutput("IMAGE[76]", 32'(IMAGE[76]), 32'd244);

    $display("[TB] strobe lane 0 off leaves pixel untouched");
    writeTxn(5, 32'h0000_00C3, 4'hE, 0);

    $display("[TB] control register");
    writeTxn(ADDR_CTRL, 32'h1, 4'h1, 0);
    checkOutput("NEW_IMAGE_after_1", 32'(NEW_IMAGE), 32'd1);
    writeTxn(ADDR_CTRL, 32'h0, 4'h1, 0);
    checkOutput("NEW_IMAGE_after_0", 32'(NEW_IMAGE), 32'd0);

    $display("[TB] status reads");
    readTxn(ADDR_STATUS, 1'b0, 8'd3, 0);
    checkOutput("status_not_ready", RDATA, 32'h0000_0003);
    for (int i = 0; i < 3; i++) readTxn(ADDR_STATUS, 1'b1, 8'd5, i);
    checkOutput("status_ready", RDATA, 32'h8000_0005);
    checkOutput("status_digit", 32'(RDATA[7:0]), 32'd5);

    $display("[TB] B backpressure blocks the next write");
    modelImg[10] = 8'h5A;
    bQueue.push_back(RESP_OKAY);
    BREADY = 1'b0; AWADDR = 32'd10; WDATA = 32'h5A; WSTRB = 4'h1;
    AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
    if (!AWREADY) flagTimeout("bp_AWREADY_wait");
    @(posedge ACLK);
    #1 AWADDR = 32'd11; WDATA = 32'hA5;
    sawReady = 1'b0;
    sawBDrop = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      if (AWREADY || WREADY) sawReady = 1'b1;
      if (!BVALID) sawBDrop = 1'b1;
    end
    checkOutput("bp_no_second_AWREADY", 32'(sawReady), 32'd0);
    checkOutput("bp_BVALID_held", 32'(sawBDrop), 32'd0);
    @(posedge ACLK);
    #1 BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    modelImg[11] = 8'hA5;
    bQueue.push_back(RESP_OKAY);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
    if (!AWREADY) flagTimeout("bp_second_AWREADY_wait");
    @(posedge ACLK);
    #1 AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!BVALID && n < 50);
    if (!BVALID) flagTimeout("bp_second_BVALID_wait");
    @(posedge ACLK);
    #1;

    $display("[TB] out-of-range accesses");
    writeTxn(300, 32'hFF, 4'h1, 0);
`ifdef S_AXI_INTERFACE_SLVERR_EN
    checkOutput("oor_write_BRESP", 32'(BRESP), 32'(RESP_SLVERR));
`else
    checkOutput("oor_write_BRESP", 32'(BRESP), 32'(RESP_OKAY));
`endif
    readTxn(300, 1'b1, 8'd9, 0);
    readTxn(ADDR_CTRL, 1'b0, 8'd0, 0);

    $display("[TB] randomized traffic");
    applyStimulus(80);

    $display("[TB] reset during a pending write response");
    writeTxn(ADDR_CTRL, 32'h1, 4'h1, 0);
    BREADY = 1'b0; AWADDR = 32'd20; WDATA = 32'h99; WSTRB = 4'h1;
    AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
    if (!AWREADY) flagTimeout("rst_mid_AWREADY_wait");
    @(posedge ACLK);
    #1 AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("pending_BVALID", 32'(BVALID), 32'd1);
    checkOutput("pending_IMAGE[20]", 32'(IMAGE[20]), 32'h99);
    ARESET = 1'b1;
    bQueue.delete();
    rQueue.delete();
    for (int i = 0; i < N; i++) modelImg[i] = 8'h00;
    modelNewImg = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("mid_rst_BVALID", 32'(BVALID), 32'd0);
    checkOutput("mid_rst_IMAGE_error_count", 32'(countImageErrors()), 32'd0);
    checkOutput("mid_rst_NEW_IMAGE", 32'(NEW_IMAGE), 32'd0);
    @(posedge ACLK);
    #1 ARESET = 1'b0; BREADY = 1'b1;
    writeTxn(7, 32'h42, 4'h1, 1);
    readTxn(ADDR_STATUS, 1'b1, 8'd7, 0);

    checkOutput("B_queue_left", 32'(bQueue.size()), 32'd0);
    checkOutput("R_queue_left", 32'(rQueue.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
